// File: rtl/regfile_sweep_master.sv
// regfile_sweep_master: drives the register file write port and read port 1
// to run CLEAR / LOAD / DUMP sweeps over an inclusive, wrapping address range.
module regfile_sweep_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_first,
  input  logic [ADDR_WIDTH-1:0] cmd_last,
  // load stream
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  // dump stream
  output logic                  dmp_valid,
  input  logic                  dmp_ready,
  output logic [DATA_WIDTH-1:0] dmp_data,
  output logic [ADDR_WIDTH-1:0] dmp_addr,
  output logic                  dmp_last,
  // register file ports
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [DATA_WIDTH-1:0] ReadData1,
  // status
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DUMP
  } state_t;

  localparam logic [1:0] OP_DUMP  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   ptr_d;
  logic [ADDR_WIDTH-1:0]   last_q;
  logic                    exhausted_q;
  logic                    dmp_valid_q;
  logic [DATA_WIDTH-1:0]   dmp_data_q;
  logic [ADDR_WIDTH-1:0]   dmp_addr_q;
  logic                    dmp_last_q;
  logic                    done_q;
  logic                    at_last;
  logic                    capture;

  // Pointer advance wraps naturally at the register count.
  assign ptr_d   = ptr_q + ADDR_WIDTH'(1);
  assign at_last = (ptr_q == last_q);
  // Output slot refills when empty or being drained, until the last beat is in.
  assign capture = (!dmp_valid_q || dmp_ready) && !exhausted_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dmp_valid = dmp_valid_q;
  assign dmp_data  = dmp_data_q;
  assign dmp_addr  = dmp_addr_q;
  assign dmp_last  = dmp_last_q;

  // Sweep FSM: command latch, pointer walk, dump output slot and done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      exhausted_q <= 1'b0;
      dmp_valid_q <= 1'b0;
      dmp_data_q  <= '0;
      dmp_addr_q  <= '0;
      dmp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            ptr_q       <= cmd_first;
            last_q      <= cmd_last;
            exhausted_q <= 1'b0;
            case (cmd_op)
              OP_DUMP:  state_q <= S_DUMP;
              OP_LOAD:  state_q <= S_LOAD;
              OP_CLEAR: state_q <= S_CLEAR;
              default:  done_q  <= 1'b1;
            endcase
          end
        end
        S_CLEAR: begin
          ptr_q <= ptr_d;
          if (at_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_d;
            if (at_last) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (capture) begin
            dmp_valid_q <= 1'b1;
            dmp_data_q  <= ReadData1;
            dmp_addr_q  <= ptr_q;
            dmp_last_q  <= at_last;
            exhausted_q <= at_last;
            ptr_q       <= ptr_d;
          end else if (dmp_ready) begin
            dmp_valid_q <= 1'b0;
          end
          if (dmp_valid_q && dmp_ready && dmp_last_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register file port drive, active only in the owning state.
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ld_ready      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        RegWrite      = 1'b1;
        WriteRegister = ptr_q;
      end
      S_LOAD: begin
        ld_ready      = 1'b1;
        RegWrite      = ld_valid;
        WriteRegister = ptr_q;
        WriteData     = ld_data;
      end
      S_DUMP: begin
        ReadRegister1 = ptr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sweep_master.sv
// Bench for regfile_sweep_master: a register file environment, a transaction
// level model (address lists and shadow contents) and literal spot checks.
module tb_regfile_sweep_master;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_first = '0;
  logic [4:0]  cmd_last = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        dmp_valid;
  logic        dmp_ready = 1'b0;
  logic [31:0] dmp_data;
  logic [4:0]  dmp_addr;
  logic        dmp_last;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [31:0] ReadData1;
  logic        busy;
  logic        done;

  regfile_sweep_master #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_first(cmd_first), .cmd_last(cmd_last),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .dmp_valid(dmp_valid), .dmp_ready(dmp_ready), .dmp_data(dmp_data),
    .dmp_addr(dmp_addr), .dmp_last(dmp_last),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadData1(ReadData1),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Register file environment: register 0 hardwired to zero.
  logic [31:0] rf [32] = '{default: '0};
  always @(posedge Clk) if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
  assign ReadData1 = (ReadRegister1 == 5'd0) ? 32'h0 : rf[ReadRegister1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model
  typedef enum int {M_NONE, M_CLEAR, M_LOAD, M_DUMP} mmode_t;
  typedef struct packed {logic [4:0] a; logic [31:0] d; logic l;} beat_t;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;

  mmode_t      m_mode = M_NONE;
  logic [4:0]  m_addrs[$];
  beat_t       m_beats[$];
  logic [31:0] mem_m [32] = '{default: '0};
  bit          m_done = 1'b0;
  int          m_dcyc = 0;
  beat_t       got[$];
  wr_t         wlog[$];

  bit          was_busy;
  logic        e_we;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;
  logic [4:0]  pa;

  function automatic void sweep(input logic [4:0] f, input logic [4:0] l);
    logic [4:0] a;
    m_addrs.delete();
    for (int i = 0; i < 32; i++) begin
      a = 5'((int'(f) + i) % 32);
      m_addrs.push_back(a);
      if (a == l) break;
    end
  endfunction

  // Compare process: every cycle, outputs against the model, then advance it.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_RegWrite", RegWrite, 0);
      check("rst_dmp_valid", dmp_valid, 0);
      check("rst_ld_ready", ld_ready, 0);
      m_mode = M_NONE;
      m_addrs.delete();
      m_beats.delete();
      m_done = 1'b0;
    end else begin
      was_busy = (m_mode != M_NONE);
      check("cmd_ready", cmd_ready, !was_busy);
      check("busy", busy, was_busy);
      check("done", done, m_done);
      m_done = 1'b0;
      check("ld_ready", ld_ready, m_mode == M_LOAD);
      case (m_mode)
        M_CLEAR: begin e_we = 1'b1;     e_wr = m_addrs[0]; e_wd = 32'h0;   end
        M_LOAD:  begin e_we = ld_valid; e_wr = m_addrs[0]; e_wd = ld_data; end
        default: begin e_we = 1'b0;     e_wr = 5'd0;       e_wd = 32'h0;   end
      endcase
      check("RegWrite", RegWrite, e_we);
      check("WriteRegister", WriteRegister, e_wr);
      check("WriteData", WriteData, e_wd);
      if (m_mode != M_DUMP) check("ReadRegister1_inactive", ReadRegister1, 0);
      check("dmp_valid", dmp_valid, (m_mode == M_DUMP) && (m_dcyc >= 1));
      if (m_mode == M_DUMP && dmp_valid && m_beats.size() > 0) begin
        check("dmp_addr", dmp_addr, m_beats[0].a);
        check("dmp_data", dmp_data, m_beats[0].d);
        check("dmp_last", dmp_last, m_beats[0].l);
      end
      if (RegWrite) wlog.push_back(wr_t'{a: WriteRegister, d: WriteData});
      if (dmp_valid && dmp_ready) got.push_back(beat_t'{a: dmp_addr, d: dmp_data, l: dmp_last});
      case (m_mode)
        M_CLEAR: begin
          pa = m_addrs.pop_front();
          if (pa != 5'd0) mem_m[pa] = 32'h0;
          if (m_addrs.size() == 0) begin m_mode = M_NONE; m_done = 1'b1; end
        end
        M_LOAD: if (ld_valid) begin
          pa = m_addrs.pop_front();
          if (pa != 5'd0) mem_m[pa] = ld_data;
          if (m_addrs.size() == 0) begin m_mode = M_NONE; m_done = 1'b1; end
        end
        M_DUMP: begin
          if (dmp_valid && dmp_ready && m_beats.size() > 0) begin
            void'(m_beats.pop_front());
            if (m_beats.size() == 0) begin m_mode = M_NONE; m_done = 1'b1; end
          end
          m_dcyc++;
        end
        default: ;
      endcase
      if (!was_busy && cmd_valid) begin
        case (cmd_op)
          2'b10: begin sweep(cmd_first, cmd_last); m_mode = M_CLEAR; end
          2'b01: begin sweep(cmd_first, cmd_last); m_mode = M_LOAD; end
          2'b00: begin
            sweep(cmd_first, cmd_last);
            m_beats.delete();
            foreach (m_addrs[i])
              m_beats.push_back(beat_t'{a: m_addrs[i],
                                        d: (m_addrs[i] == 5'd0) ? 32'h0 : mem_m[m_addrs[i]],
                                        l: (i == m_addrs.size() - 1)});
            m_addrs.delete();
            m_dcyc = 0;
            m_mode = M_DUMP;
          end
          default: m_done = 1'b1;
        endcase
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] f, input logic [4:0] l);
    cmd_op = op; cmd_first = f; cmd_last = l; cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge Clk); n++; end while (busy && n < budget);
    check("idle_timeout", busy, 0);
    @(posedge Clk); #1;
  endtask

  task automatic load_words(input logic [31:0] words[$], input int gap_idx, input int gap_len);
    for (int i = 0; i < words.size(); i++) begin
      ld_valid = 1'b1; ld_data = words[i];
      @(posedge Clk); #1;
      ld_valid = 1'b0;
      if (i == gap_idx) repeat (gap_len) begin @(posedge Clk); #1; end
    end
  endtask

  task automatic do_dump(input logic [4:0] f, input logic [4:0] l);
    got.delete();
    dmp_ready = 1'b1;
    issue(2'b00, f, l);
    wait_idle(100);
  endtask

  logic [31:0] wq[$];
  int          bad;
  int          nbeats;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    check("init_cmd_ready", cmd_ready, 1);
    check("init_dmp_data", dmp_data, 0);
    check("init_WriteRegister", WriteRegister, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // 1: preload 1..31, CLEAR 1..31, DUMP back zeros
    wq.delete();
    for (int i = 1; i < 32; i++) wq.push_back(32'hC0DE0000 + 32'(i));
    issue(2'b01, 5'd1, 5'd31);
    load_words(wq, -1, 0);
    wait_idle(10);
    wlog.delete();
    issue(2'b10, 5'd1, 5'd31);
    wait_idle(60);
    check("t1_clear_writes", wlog.size(), 31);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].a != 5'(i + 1) || wlog[i].d != 32'h0) bad++;
    check("t1_clear_seq_bad", bad, 0);
    do_dump(5'd1, 5'd31);
    check("t1_dump_beats", got.size(), 31);
    bad = 0;
    foreach (got[i]) if (got[i].d != 32'h0) bad++;
    check("t1_dump_nonzero", bad, 0);

    // 2: LOAD 5..8 with a two-cycle gap after the second word
    wlog.delete();
    issue(2'b01, 5'd5, 5'd8);
    load_words('{32'hA5A50005, 32'hA5A50006, 32'hA5A50007, 32'hA5A50008}, 1, 2);
    wait_idle(10);
    check("t2_writes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t2_wr0_addr", wlog[0].a, 5);
      check("t2_wr3_addr", wlog[3].a, 8);
    end
    do_dump(5'd5, 5'd8);
    check("t2_dump_beats", got.size(), 4);
    if (got.size() == 4) begin
      check("t2_dump0", got[0].d, 32'hA5A50005);
      check("t2_dump2", got[2].d, 32'hA5A50007);
      check("t2_dump3", got[3].d, 32'hA5A50008);
    end

    // 3: preload 0x100000nn, DUMP 30..1 wrapping
    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back(32'h10000000 + 32'(i));
    issue(2'b01, 5'd0, 5'd31);
    load_words(wq, -1, 0);
    wait_idle(10);
    do_dump(5'd30, 5'd1);
    check("t3_dump_beats", got.size(), 4);
    if (got.size() == 4) begin
      check("t3_b0", {got[0].a, got[0].d, got[0].l}, {5'd30, 32'h1000001E, 1'b0});
      check("t3_b1", {got[1].a, got[1].d, got[1].l}, {5'd31, 32'h1000001F, 1'b0});
      check("t3_b2", {got[2].a, got[2].d, got[2].l}, {5'd0,  32'h00000000, 1'b0});
      check("t3_b3", {got[3].a, got[3].d, got[3].l}, {5'd1,  32'h10000001, 1'b1});
    end

    // 4: DUMP 0..31 with dmp_ready toggling and a 5-cycle stall
    got.delete();
    issue(2'b00, 5'd0, 5'd31);
    for (int c = 0; c < 300; c++) begin
      dmp_ready = (c >= 20 && c < 25) ? 1'b0 : ((c % 2) == 1);
      @(negedge Clk);
      if (!busy) break;
      @(posedge Clk); #1;
    end
    check("t4_idle", busy, 0);
    @(posedge Clk); #1;
    dmp_ready = 1'b1;
    nbeats = got.size();
    check("t4_beats", nbeats, 32);
    bad = 0;
    foreach (got[i])
      if (got[i].a != 5'(i) || got[i].d != ((i == 0) ? 32'h0 : 32'h10000000 + 32'(i))) bad++;
    check("t4_order_bad", bad, 0);

    // 5: reset after two of four LOAD words
    issue(2'b01, 5'd5, 5'd8);
    load_words('{32'hB0000005, 32'hB0000006}, -1, 0);
    Reset_n = 1'b0;
    #1;
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_ld_ready", ld_ready, 0);
    check("t5_wport", {RegWrite, WriteRegister, WriteData}, 0);
    check("t5_rr1", ReadRegister1, 0);
    check("t5_dmp", {dmp_valid, dmp_data, dmp_addr, dmp_last, done}, 0);
    repeat (2) begin @(posedge Clk); #1; end
    Reset_n = 1'b1;
    wlog.delete();
    issue(2'b10, 5'd20, 5'd21);
    wait_idle(10);
    check("t5_clear_writes", wlog.size(), 2);
    do_dump(5'd5, 5'd8);
    check("t5_dump_beats", got.size(), 4);
    if (got.size() == 4) begin
      check("t5_r5", got[0].d, 32'hB0000005);
      check("t5_r6", got[1].d, 32'hB0000006);
      check("t5_r7", got[2].d, 32'h10000007);
      check("t5_r8", got[3].d, 32'h10000008);
    end

    // 6: command while busy is ignored; reserved op pulses done only
    wlog.delete();
    got.delete();
    dmp_ready = 1'b0;
    issue(2'b00, 5'd0, 5'd3);
    cmd_op = 2'b10; cmd_first = 5'd0; cmd_last = 5'd31; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("t6_cmd_ready_busy", cmd_ready, 0);
      @(posedge Clk); #1;
    end
    cmd_valid = 1'b0;
    dmp_ready = 1'b1;
    wait_idle(20);
    check("t6_no_writes", wlog.size(), 0);
    check("t6_dump_beats", got.size(), 4);
    got.delete();
    issue(2'b11, 5'd0, 5'd31);
    @(negedge Clk);
    check("t6_rsv_done", done, 1);
    check("t6_rsv_busy", busy, 0);
    repeat (3) @(negedge Clk);
    check("t6_rsv_no_writes", wlog.size(), 0);
    check("t6_rsv_no_beats", got.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sweep_master.md
Name: regfile_sweep_master

Overview:
- Initiator-side controller that drives the 32x32 MIPS register file's write port and read port 1, issuing address-range sweeps.
- Supports three commands: CLEAR (zero-fill), LOAD (write words from an input stream) and DUMP (read registers out as an output stream).
- Used by the debug/boot path to initialise or snapshot architectural registers while the core is halted.

Parameters:
DATA_WIDTH, 32, register word width
ADDR_WIDTH, 5, register address width (32 registers)

Ports:
Clk  in  1  clock; all state changes on the rising edge
Reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 DUMP, 01 LOAD, 10 CLEAR, 11 reserved
cmd_first  in  ADDR_WIDTH  first register of the sweep
cmd_last  in  ADDR_WIDTH  last register of the sweep (inclusive)
ld_valid  in  1  load word offered
ld_ready  out  1  load word accepted
ld_data  in  DATA_WIDTH  load word
dmp_valid  out  1  dump beat valid
dmp_ready  in  1  dump beat accepted
dmp_data  out  DATA_WIDTH  register contents
dmp_addr  out  ADDR_WIDTH  register address of this beat
dmp_last  out  1  final beat of the sweep
RegWrite  out  1  register file write enable
WriteRegister  out  ADDR_WIDTH  register file write address
WriteData  out  DATA_WIDTH  register file write data
ReadRegister1  out  ADDR_WIDTH  register file read address
ReadData1  in  DATA_WIDTH  register file asynchronous read data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (Reset_n low, asynchronous):
  - FSM goes to IDLE and ptr is cleared to 0.
  - dmp_valid, dmp_data, dmp_addr, dmp_last, done, busy, RegWrite, WriteRegister, WriteData, ReadRegister1 and ld_ready are all 0.
  - cmd_ready is 1.
  - Reset mid-command abandons the command immediately. Register file writes already performed persist.
- FSM states: IDLE, CLEAR, LOAD, DUMP.
  - cmd_ready = (state==IDLE).
  - A handshake in IDLE latches op, first and last, sets ptr=first, and enters the state for the op on the next edge.
  - op 11 stays in IDLE and pulses done on the next cycle, with no port activity.
- Sweep order: ptr increments modulo 32.
  - first==last gives one register.
  - first>last wraps; e.g. 30,31,0,1.
  - first=0,last=31 gives all 32 registers.
- CLEAR:
  - Every cycle: RegWrite=1, WriteRegister=ptr, WriteData=0, then ptr++.
  - After the write to ptr==last, go to IDLE.
  - N registers take exactly N cycles.
- LOAD:
  - ld_ready=1.
  - RegWrite=ld_valid, combinationally. WriteRegister=ptr, WriteData=ld_data.
  - ptr++ only on a handshake. The handshake at ptr==last returns to IDLE.
  - Gaps in ld_valid stall the sweep, with no writes.
- DUMP:
  - ReadRegister1=ptr, combinationally.
  - Single-entry output register, loaded when (!dmp_valid || dmp_ready) and the sweep is not yet exhausted. Loading captures dmp_data=ReadData1, dmp_addr=ptr, dmp_last=(ptr==last), then ptr++.
  - Once the last beat is captured, no further captures occur.
  - On a dmp_valid&&dmp_ready&&dmp_last handshake, go to IDLE.
  - dmp_valid clears when a beat is accepted without a new capture.
  - Beat outputs stay stable while dmp_valid&&!dmp_ready.
  - Throughput is 1 beat/cycle with dmp_ready high.
  - dmp_valid first rises on the second edge after the command handshake.
- Outside their active state: RegWrite, WriteRegister and WriteData are 0, ReadRegister1 is 0, and ld_ready is 0.
- done is registered: high for exactly one cycle, on the cycle following the final write, handshake or beat acceptance. cmd_ready is already 1 in that cycle.
- Register 0 receives no special treatment. The register file itself forces it to zero, so a DUMP of register 0 returns 0.
- cmd_valid while busy is ignored. ld_valid outside LOAD is ignored.

Test Plan:
1. Preload regs 1..31 with nonzero values, then CLEAR first=1,last=31 -> RegWrite high for 31 consecutive cycles, WriteRegister 1..31, WriteData 0; done one cycle after the last write; a following DUMP 1..31 returns all zeros.
2. LOAD first=5,last=8 with ld_data 0xA5A50005..0xA5A50008 and ld_valid dropped for 2 cycles between words 2 and 3 -> exactly 4 writes to addresses 5,6,7,8 with no write during the gap; a following DUMP returns those values.
3. Regs preloaded with 0x100000nn (nn = register index), then DUMP first=30,last=1 -> beats addr 30,31,0,1 with data 0x1000001E, 0x1000001F, 0x00000000, 0x10000001; dmp_last only on the 4th beat; done the following cycle.
4. DUMP 0..31 with dmp_ready toggling every cycle and a 5-cycle stall mid-sweep -> 32 beats in order, with no duplicates or drops; data/addr stable during stalls.
5. Assert Reset_n low after 2 of the 4 words of LOAD 5..8 -> all outputs at reset values immediately; regs 5,6 updated, 7,8 unchanged; a new CLEAR is accepted right after reset release.
6. Issue cmd_valid during an active DUMP -> the command is not accepted (cmd_ready=0); op=11 in IDLE -> one done pulse with no RegWrite and no dmp_valid.
